irq_pending_arbiter: RTL and testbench
======================================

// Module: irq_pending_arbiter
// PURPOSE
//  Upstream stage for the 4-input priority-encode path. Captures request lines into a
//  pending register and applies a mask. Presents the highest-index pending, unmasked
//  request as a 2-bit ID over a valid/ready handshake. Clears the served bit on acceptance.
//  Turns raw, bursty request lines into a stable, one-at-a-time encoded stream for the
//  downstream consumer.
// PARAMETERS
//  N_REQ   4   number of request lines; fixed at 4, priority is highest index
//  ID_W    2   width of irq_id; equals clog2(N_REQ)
//  DROP_W  8   width of the saturating dropped-event counter
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous reset, active-high
//  en         in   1       1 = grants may start; 0 = no new grant, in-flight grant completes
//  req        in   4       request lines, sampled every clk
//  mask       in   4       1 = request line may be granted; pending still records it
//  irq_valid  out  1       an ID is being presented
//  irq_id     out  ID_W    ID of the presented request; stable while irq_valid=1
//  irq_ready  in   1       consumer accepts when irq_valid && irq_ready
//  pending    out  4       current pending register
//  drop_cnt   out  DROP_W  count of request events that hit an already-pending bit; saturates
// BEHAVIOUR
//  - Reset (rst=1 at clk edge):
//    - pending=0, irq_valid=0, irq_id=0, drop_cnt=0, FSM=IDLE.
//    - Edge-detect history register=0.
//    - Reset applies in any state; an in-flight grant is discarded without a handshake.
//  - Set event for bit k: see CONFIGURATION. pending[k] is set on the clk edge after the event.
//  - Drop: a set event on bit k while pending[k]=1 and bit k is not being cleared this cycle
//    increments drop_cnt by 1. drop_cnt saturates at all-ones.
//  - Each set event hits an already-pending bit at most once; any number of bits may set in
//    one cycle. drop_cnt adds the number of dropped bits that cycle, clamped at saturation.
//  - FSM states: IDLE, PRESENT.
//    - IDLE -> PRESENT when en=1 and (pending & mask)!=0.
//      On entry: irq_id <= priority-encoded index of (pending & mask), highest bit wins;
//      irq_valid <= 1.
//    - PRESENT: irq_valid=1. irq_id is held stable regardless of mask, en or new requests.
//      No retraction.
//    - PRESENT -> IDLE on irq_valid && irq_ready: pending[irq_id] cleared; irq_valid <= 0.
//  - Latency: a request event at edge T sets pending at T+1 and asserts irq_valid at T+2.
//  - Acceptance at edge A gives irq_valid=0 for cycle A+1. The next grant is earliest at
//    A+2 (one-cycle bubble).
//  - Simultaneous clear and set on the same bit: set wins, pending stays 1, not counted as
//    a drop.
//  - en falls while PRESENT: the handshake still completes, then the FSM stays in IDLE.
//  - All pending bits masked: the FSM stays in IDLE; pending is retained.
//  - irq_ready while IDLE is ignored.
// CONFIGURATION
//  Macro IRQ_PEND_EDGE_EN:
//  - Defined: set event for bit k = rising edge of req[k] (req[k]=1 and previous sample 0).
//    Uses a 4-bit history register.
//  - Undefined: set event for bit k = req[k]=1 (level). A held request re-pends on the cycle
//    after it is cleared. Each cycle it is high while already pending counts as a drop.
// STRUCTURE
//  - Shared package irq_pkg:
//    - localparams N_REQ=4, ID_W=2.
//    - typedef enum {IDLE, PRESENT} irq_state_t.
//  - One sub-module: prio_enc4. Pure combinational.
//    - Input: 4-bit vector. Outputs: ID_W index (highest set bit) and any_set flag.
//    - Instantiated once on (pending & mask).
// TESTING
//  1. rst=1, then release; req=0 -> pending=0, irq_valid=0, drop_cnt=0 for 10 cycles.
//  2. mask=4'hF, en=1, req=4'b0101 for 1 cycle, irq_ready=1:
//     -> irq_id=2 at T+2, then irq_id=0 at T+4, then pending=0.
//  3. Backpressure: irq_ready=0 for 5 cycles while req[3] rises mid-wait on an id=1 grant
//     -> irq_id stays 1. After accept, next irq_id=3.
//  4. Same-bit collision: pending[2]=1 being accepted while a req[2] set event occurs
//     -> pending[2] stays 1, drop_cnt unchanged, id=2 re-presented.
//  5. mask=4'b0000 with pending=4'hF -> no irq_valid. mask->4'b0010 -> irq_id=1.
//     Repeated set events on bit 0 drive drop_cnt to 255 and hold it there.
//  6. rst asserted during PRESENT -> next cycle irq_valid=0, pending=0.
//     Run with and without IRQ_PEND_EDGE_EN: a held req[1] yields one grant vs repeated grants.

Source files
------------

// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM state type and bit-count helper for irq_pending_arbiter
package irq_pkg;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int DROP_W = 8;

  typedef enum logic [0:0] {IDLE, PRESENT} irq_state_t;

  function automatic logic [2:0] popcount4(input logic [N_REQ-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < N_REQ; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/irq_pending_arbiter_if.sv
// rtl/irq_pending_arbiter_if.sv - valid/ready handshake carrying the granted request ID
interface irq_pending_arbiter_if;
  import irq_pkg::*;

  logic            irq_valid;
  logic [ID_W-1:0] irq_id;
  logic            irq_ready;

  modport master (output irq_valid, output irq_id, input irq_ready);
  modport slave  (input irq_valid, input irq_id, output irq_ready);

endinterface

// File: rtl/prio_enc4.sv
// rtl/prio_enc4.sv - combinational 4-input priority encoder, highest set index wins
module prio_enc4
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] vec,
  output logic [ID_W-1:0]  idx,
  output logic             any_set
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec[i]) idx = i[ID_W-1:0];
    end
    any_set = |vec;
  end

endmodule

// File: rtl/irq_pending_arbiter.sv
// rtl/irq_pending_arbiter.sv - pending/mask capture with one-at-a-time ID grant over valid/ready
// Optional IRQ_PEND_EDGE_EN: set events on rising edges of req instead of level.
module irq_pending_arbiter
  import irq_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ-1:0]           mask,
  irq_pending_arbiter_if.master      irq,
  output logic [N_REQ-1:0]           pending,
  output logic [DROP_W-1:0]          drop_cnt
);

  irq_state_t        state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [N_REQ-1:0]  pend_q;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [N_REQ-1:0]  set_ev, clr_vec, drop_vec, masked;
  logic [ID_W-1:0]   enc_id;
  logic              enc_any;
  logic              accept;
  logic [DROP_W:0]   drop_sum;

`ifdef IRQ_PEND_EDGE_EN
  logic [N_REQ-1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) hist_q <= '0;
    else     hist_q <= req;
  end

  assign set_ev = req & ~hist_q;
`else
  assign set_ev = req;
`endif

  assign masked = pend_q & mask;

  prio_enc4 u_enc (
    .vec     (masked),
    .idx     (enc_id),
    .any_set (enc_any)
  );

  assign accept = (state_q == PRESENT) && irq.irq_ready;

  always_comb begin
    clr_vec = '0;
    if (accept) clr_vec[id_q] = 1'b1;
  end

  // A set landing on the bit being cleared wins and is not a drop.
  assign drop_vec = set_ev & pend_q & ~clr_vec;
  assign drop_sum = {1'b0, drop_q} + {{(DROP_W-2){1'b0}}, popcount4(drop_vec)};
  assign drop_d   = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (en && enc_any) begin
          state_d = PRESENT;
          id_d    = enc_id;
        end
      end
      PRESENT: begin
        if (irq.irq_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      pend_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pend_q  <= (pend_q & ~clr_vec) | set_ev;
      drop_q  <= drop_d;
    end
  end

  assign irq.irq_valid = (state_q == PRESENT);
  assign irq.irq_id    = id_q;
  assign pending       = pend_q;
  assign drop_cnt      = drop_q;

endmodule

// File: tb/tb_irq_pending_arbiter.sv
// tb/tb_irq_pending_arbiter.sv - randomized and directed checks against a behavioural model
module tb_irq_pending_arbiter;
  import irq_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [N_REQ-1:0]  req;
  logic [N_REQ-1:0]  mask;
  logic [N_REQ-1:0]  pending;
  logic [DROP_W-1:0] drop_cnt;

  irq_pending_arbiter_if bus ();

  irq_pending_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .req      (req),
    .mask     (mask),
    .irq      (bus),
    .pending  (pending),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit m_pend [N_REQ];
  bit m_prev [N_REQ];
  bit m_valid;
  int m_id;
  int m_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < N_REQ; k++) v[k] = m_pend[k];
    return v;
  endfunction

  // What the next clock edge should do, given the current inputs.
  task automatic model_step();
    bit new_pend [N_REQ];
    bit accepted;
    bit ev;
    bit cleared;
    int grant;
    if (rst) begin
      for (int k = 0; k < N_REQ; k++) begin
        m_pend[k] = 0;
        m_prev[k] = 0;
      end
      m_valid = 0;
      m_id    = 0;
      m_drop  = 0;
      return;
    end
    accepted = m_valid && bus.irq_ready;
    for (int k = 0; k < N_REQ; k++) begin
`ifdef IRQ_PEND_EDGE_EN
      ev = req[k] && !m_prev[k];
`else
      ev = req[k];
`endif
      cleared = accepted && (m_id == k);
      if (ev && m_pend[k] && !cleared && m_drop < 255) m_drop++;
      new_pend[k] = ev ? 1'b1 : (cleared ? 1'b0 : m_pend[k]);
    end
    if (m_valid) begin
      if (accepted) m_valid = 0;
    end else if (en) begin
      grant = -1;
      for (int k = 0; k < N_REQ; k++) if (m_pend[k] && mask[k]) grant = k;
      if (grant >= 0) begin
        m_valid = 1;
        m_id    = grant;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      m_pend[k] = new_pend[k];
      m_prev[k] = req[k];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("irq_valid", {31'b0, bus.irq_valid}, {31'b0, m_valid});
    check("irq_id", {30'b0, bus.irq_id}, m_id);
    check("pending", {28'b0, pending}, model_pend());
    check("drop_cnt", {24'b0, drop_cnt}, m_drop);
  endtask

  int unsigned drop_before;
  int          grants;

  initial begin
    rst = 1'b1; en = 1'b0; req = '0; mask = '0; bus.irq_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_pending", {28'b0, pending}, 0);
      check("idle_valid", {31'b0, bus.irq_valid}, 0);
      check("idle_drop", {24'b0, drop_cnt}, 0);
    end

    // Two-request burst drained highest index first.
    mask = 4'hF; en = 1'b1; bus.irq_ready = 1'b1;
    req = 4'b0101; tick();
    req = 4'b0000; tick();
    check("burst_first_id", {30'b0, bus.irq_id}, 2);
    check("burst_first_valid", {31'b0, bus.irq_valid}, 1);
    tick();
    check("burst_bubble", {31'b0, bus.irq_valid}, 0);
    tick();
    check("burst_second_id", {30'b0, bus.irq_id}, 0);
    tick();
    check("burst_done", {28'b0, pending}, 0);

    // Backpressure: ID held while a higher request arrives.
    bus.irq_ready = 1'b0;
    req = 4'b0010; tick();
    req = 4'b0000; tick();
    for (int i = 0; i < 5; i++) begin
      req = (i == 2) ? 4'b1000 : 4'b0000;
      tick();
      check("bp_hold_id", {30'b0, bus.irq_id}, 1);
    end
    req = 4'b0000;
    bus.irq_ready = 1'b1; tick();
    tick();
    check("bp_next_id", {30'b0, bus.irq_id}, 3);
    tick();

    // Set event on the bit being accepted.
    bus.irq_ready = 1'b0;
    req = 4'b0100; tick();
    req = 4'b0000; tick();
    drop_before = drop_cnt;
    req = 4'b0100; bus.irq_ready = 1'b1; tick();
    check("coll_pending2", {31'b0, pending[2]}, 1);
    check("coll_drop", {24'b0, drop_cnt}, drop_before);
    req = 4'b0000; tick();
    tick();
    check("coll_represent", {30'b0, bus.irq_id}, 2);
    tick();

    // Everything masked, then unmask one bit, then saturate drop_cnt.
    bus.irq_ready = 1'b0; mask = 4'b0000;
    req = 4'hF; tick();
    req = 4'h0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("masked_valid", {31'b0, bus.irq_valid}, 0);
      check("masked_pending", {28'b0, pending}, 4'hF);
    end
    mask = 4'b0010; tick();
    check("unmask_id", {30'b0, bus.irq_id}, 1);
    for (int i = 0; i < 600; i++) begin
      req = req ^ 4'b0001;
      tick();
    end
    check("drop_sat", {24'b0, drop_cnt}, 255);
    req = 4'b0000; tick(); tick();
    check("drop_sat_hold", {24'b0, drop_cnt}, 255);

    // Reset while presenting.
    rst = 1'b1; tick();
    check("rst_valid", {31'b0, bus.irq_valid}, 0);
    check("rst_pending", {28'b0, pending}, 0);
    rst = 1'b0;

    // Held request: one grant on edges, repeated grants on level.
    mask = 4'hF; bus.irq_ready = 1'b1; req = 4'b0010;
    grants = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.irq_valid) grants++;
    end
`ifdef IRQ_PEND_EDGE_EN
    check("held_grants", grants, 1);
`else
    check("held_grants_many", {31'b0, grants >= 5}, 1);
`endif
    req = 4'b0000;

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rst           = ($urandom_range(0, 63) == 0);
      en            = ($urandom_range(0, 7) != 0);
      bus.irq_ready = $urandom_range(0, 1) == 1;
      mask          = 4'($urandom);
      for (int k = 0; k < N_REQ; k++) req[k] = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
